// File: rtl/aes_pkg.sv
// Shared AES datapath types and byte-slice helpers.
// Column-major state: byte i = state[127-8i -: 8].
package aes_pkg;

  localparam int AES_NBYTES = 16;
  localparam int BYTE_W = 8;

  // LSB position of byte 0 in a 128-bit state.
  localparam logic [6:0] BYTE0_LO = 7'd120;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_t;

  // LSB index of byte idx within a 128-bit state.
  function automatic logic [6:0] byte_lo(
    input logic [3:0] idx
  );
    return BYTE0_LO - {idx, 3'b000};
  endfunction

endpackage

// File: rtl/shift_rows_idx.sv
// ShiftRows destination index: byte idx -> placement.
// Ports: idx (source byte), dest (destination byte).
module shift_rows_idx #(
  parameter int SHIFT_ROWS = 1
) (
  input  logic [3:0] idx,
  output logic [3:0] dest
);

  logic [1:0] row;
  logic [1:0] col;
  logic [1:0] col_d;

  assign row = idx[1:0];
  assign col = idx[3:2];
  // Row r rotates left by r columns; 2-bit wrap.
  assign col_d = col - row;

  assign dest = (SHIFT_ROWS != 0) ? {col_d, row}
                                  : idx;

endmodule

// File: rtl/sub_shift_serial.sv
// Byte-serial SubBytes + ShiftRows around an external S-box.
// Ports: clk, rst (async high), start, state_in,
// sbox_addr/sbox_data (S-box pair), busy, done,
// state_out. Option: SUBSHIFT_SBOX_PIPE_EN registers
// sbox_data before write-back (one extra RUN cycle).
module sub_shift_serial
  import aes_pkg::*;
#(
  parameter int SHIFT_ROWS = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] state_in,
  output logic [7:0]   sbox_addr,
  input  logic [7:0]   sbox_data,
  output logic         busy,
  output logic         done,
  output logic [127:0] state_out
);

  fsm_t         st;
  logic [127:0] src;
  logic [127:0] dst;
  logic [127:0] dst_nxt;
  logic [3:0]   cnt;
  logic [3:0]   dest;
  logic         running;
  logic         accept;
  logic         issue;
  logic         wr_en;
  logic         wr_last;
  logic [3:0]   wr_idx;
  logic [7:0]   wr_data;

  assign running = (st == ST_RUN);
  assign accept  = start && !running;
  assign busy    = running;
  assign done    = (st == ST_DONE);

  // cnt parks at 15 after the run, so the
  // address holds its last value outside RUN.
  assign sbox_addr = src[byte_lo(cnt) +: BYTE_W];

  shift_rows_idx #(
    .SHIFT_ROWS(SHIFT_ROWS)
  ) u_idx (
    .idx (cnt),
    .dest(dest)
  );

`ifdef SUBSHIFT_SBOX_PIPE_EN
  logic [7:0] p_data;
  logic [3:0] p_idx;
  logic       p_vld;
  logic       p_last;
  logic       fin;

  assign issue   = running && !fin;
  assign wr_en   = running && p_vld;
  assign wr_idx  = p_idx;
  assign wr_data = p_data;
  assign wr_last = p_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_data <= '0;
      p_idx  <= '0;
      p_vld  <= 1'b0;
      p_last <= 1'b0;
      fin    <= 1'b0;
    end else if (accept) begin
      p_data <= '0;
      p_idx  <= '0;
      p_vld  <= 1'b0;
      p_last <= 1'b0;
      fin    <= 1'b0;
    end else if (issue) begin
      p_data <= sbox_data;
      p_idx  <= dest;
      p_vld  <= 1'b1;
      p_last <= (cnt == 4'd15);
      fin    <= (cnt == 4'd15);
    end else begin
      p_vld  <= 1'b0;
      p_last <= 1'b0;
    end
  end
`else
  assign issue   = running;
  assign wr_en   = running;
  assign wr_idx  = dest;
  assign wr_data = sbox_data;
  assign wr_last = (cnt == 4'd15);
`endif

  always_comb begin
    dst_nxt = dst;
    if (wr_en) begin
      dst_nxt[byte_lo(wr_idx) +: BYTE_W] = wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= ST_IDLE;
      src       <= '0;
      dst       <= '0;
      cnt       <= '0;
      state_out <= '0;
    end else if (accept) begin
      st  <= ST_RUN;
      src <= state_in;
      cnt <= '0;
    end else begin
      unique case (st)
        ST_RUN: begin
          dst <= dst_nxt;
          if (issue && cnt != 4'd15) begin
            cnt <= cnt + 4'd1;
          end
          if (wr_en && wr_last) begin
            st        <= ST_DONE;
            state_out <= dst_nxt;
          end
        end
        ST_DONE: st <= ST_IDLE;
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_shift_serial.sv
// Directed bench for sub_shift_serial with an AES S-box
// model; SHIFT_ROWS=1 and SHIFT_ROWS=0 instances side by side.
module tb_sub_shift_serial;

`ifdef SUBSHIFT_SBOX_PIPE_EN
  localparam int LAT = 18;
`else
  localparam int LAT = 17;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] state_in;
  logic [7:0]   sbox_addr, sbox_addr0;
  logic [7:0]   sbox_data, sbox_data0;
  logic         busy, busy0, done, done0;
  logic [127:0] state_out, state_out0;
  logic [2047:0] sbox_tbl;

  int nchk = 0;
  int npass = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  sub_shift_serial #(.SHIFT_ROWS(1)) dut (
    .clk(clk), .rst(rst), .start(start),
    .state_in(state_in), .sbox_addr(sbox_addr),
    .sbox_data(sbox_data), .busy(busy),
    .done(done), .state_out(state_out)
  );

  sub_shift_serial #(.SHIFT_ROWS(0)) dut0 (
    .clk(clk), .rst(rst), .start(start),
    .state_in(state_in), .sbox_addr(sbox_addr0),
    .sbox_data(sbox_data0), .busy(busy0),
    .done(done0), .state_out(state_out0)
  );

  assign sbox_data  = sbox_tbl[2047 - 8*int'(sbox_addr) -: 8];
  assign sbox_data0 = sbox_tbl[2047 - 8*int'(sbox_addr0) -: 8];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    nchk++;
    assert (got === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_done(output int n);
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      tick;
      if (done) begin
        n = k;
        break;
      end
    end
  endtask

  logic [127:0] v_in, v_sr, v_sb, v_63;
  int n, nd, bad;

  initial begin
    sbox_tbl = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
    };
    v_in = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    v_sr = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    v_sb = 128'hd42711aee0bf98f1b8b45de51e415230;
    v_63 = {16{8'h63}};

    rst = 1'b1;
    start = 1'b0;
    state_in = '0;
    tick;
    tick;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out", state_out, 0);
    chk("rst_addr", sbox_addr, 0);
    rst = 1'b0;
    tick;

    // FIPS-197 round 1 SubBytes/ShiftRows.
    state_in = v_in;
    start = 1'b1;
    tick;
    start = 1'b0;
    state_in = '1;
    chk("fips_busy", busy, 1);
    chk("fips_addr0", sbox_addr, 8'h19);
    wait_done(n);
    chk("fips_lat", n + 1, LAT);
    chk("fips_sr", state_out, v_sr);
    chk("fips_sb", state_out0, v_sb);
    chk("fips_done0", done0, 1);
    chk("fips_nobusy", busy, 0);
    tick;
    chk("fips_pulse", done, 0);
    tick;
    chk("fips_hold", state_out, v_sr);
    chk("fips_addr_hold", sbox_addr, 8'h08);

    // All-zero state: address stream stays 00.
    state_in = '0;
    start = 1'b1;
    tick;
    start = 1'b0;
    bad = 0;
    n = 0;
    while (busy && n < 40) begin
      if (sbox_addr !== 8'h00) bad++;
      tick;
      n++;
    end
    chk("zero_addr", bad, 0);
    chk("zero_run_len", n, LAT - 1);
    chk("zero_done", done, 1);
    chk("zero_out", state_out, v_63);
    chk("zero_out0", state_out0, v_63);
    tick;

    // start during RUN is ignored.
    state_in = v_in;
    start = 1'b1;
    tick;
    start = 1'b0;
    state_in = '0;
    repeat (4) tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    nd = 0;
    repeat (40) begin
      if (done) nd++;
      tick;
    end
    chk("ign_ndone", nd, 1);
    chk("ign_out", state_out, v_sr);

    // Asynchronous reset mid-RUN.
    state_in = v_in;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (7) tick;
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_out", state_out, 0);
    chk("arst_addr", sbox_addr, 0);
    tick;
    rst = 1'b0;
    nd = 0;
    repeat (30) begin
      if (done) nd++;
      tick;
    end
    chk("arst_nodone", nd, 0);
    state_in = '0;
    start = 1'b1;
    tick;
    start = 1'b0;
    wait_done(n);
    chk("arst_lat", n + 1, LAT);
    chk("arst_new", state_out, v_63);
    tick;

    // start held through DONE: back-to-back.
    state_in = v_in;
    start = 1'b1;
    tick;
    state_in = '0;
    wait_done(n);
    chk("b2b_lat1", n + 1, LAT);
    chk("b2b_out1", state_out, v_sr);
    chk("b2b_out1_sb", state_out0, v_sb);
    tick;
    start = 1'b0;
    chk("b2b_noidle", busy, 1);
    n = 1;
    while (!done && n < 40) begin
      tick;
      n++;
    end
    chk("b2b_gap", n, LAT);
    chk("b2b_out2", state_out, v_63);
    tick;
    chk("b2b_pulse", done, 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
